ifetch_queue: RTL and testbench

- Parametrised successor to the single-slot instruction fetch stage.
- Holds a PC and issues one outstanding ICache request at a time.
- Consults the branch predictor combinationally on each returned instruction, then pushes {instr, pc, pred_taken} into an IQ_DEPTH-entry FIFO that feeds the decoder via valid/ready.
- ROB redirects flush the FIFO and retarget the PC. The fetcher pipelines ahead of decode instead of stalling per instruction.

---
 rtl/ifetch_queue_pkg.sv | 27 ++
 rtl/ifetch_queue_fifo.sv | 92 +++++++++
 rtl/ifetch_queue.sv | 188 ++++++++++++++++++
 tb/tb_ifetch_queue.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// ============================================================================
// Module : ifetch_queue_pkg
// Purpose: Shared definitions for the queued instruction fetch stage.
//          Holds default datapath widths, the sequential PC step and the
//          fetch FSM state encodings.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_queue_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_INSTR_W = 32;

  // Byte distance between sequential instructions.
  localparam int unsigned INSTR_STEP  = 4;

  // IDLE: free to issue a request. WAIT: one request is outstanding.
  typedef enum logic [0:0] {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

endpackage : ifetch_queue_pkg

`default_nettype wire

// File: rtl/ifetch_queue_fifo.sv
// ============================================================================
// Module : iq_fifo
// Purpose: Parametrised synchronous FIFO. Holds opaque DATA_W-bit entries;
//          the fetch stage packs {instr, pc, pred_taken} into each one.
//          Flush has priority over push/pop. A push is accepted when full
//          only if a pop frees a slot in the same cycle.
// Ports  : clk, rst_n       - clock, asynchronous active-low reset
//          flush_i          - drop all entries
//          push_i/push_data_i - write an entry at the tail
//          pop_i            - retire the head entry
//          head_data_o      - entry at the head (registered storage)
//          full_o/empty_o/count_o - occupancy status
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_fifo #(
  parameter int unsigned DATA_W = 65,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      push_data_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      head_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              w_do_push;
  logic              w_do_pop;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_data_o = mem_q[head_q];

  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_do_push) tail_d = tail_q + PTR_W'(1);
      if (w_do_pop)  head_d = head_q + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush_i) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

endmodule : iq_fifo

`default_nettype wire

// File: rtl/ifetch_queue.sv
// ============================================================================
// Module : ifetch_queue
// Purpose: Queued instruction fetch stage. Keeps one ICache request in
//          flight, consults the branch predictor on each returning
//          instruction and buffers {instr, pc, pred_taken} in an
//          IQ_DEPTH-entry FIFO that feeds decode over valid/ready.
//          ROB redirects flush the queue and retarget the PC; a response
//          still in flight across a redirect is discarded on arrival.
// Build  : define IFETCH_BYPASS_EN to let an accepted response reach
//          dec_* combinationally when the queue is empty and decode is
//          ready (the entry is then not written into the queue).
// Ports  : clk, rst_n, rdy              - clock, async reset, global stall
//          redirect_valid/redirect_pc   - ROB redirect
//          icache_req_valid/_addr       - fetch request
//          icache_resp_valid/_instr     - fetch response
//          bp_pc/bp_instr -> bp_taken/bp_target - predictor lookup
//          dec_valid/instr/pc/pred_taken, dec_ready - decode handshake
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter int unsigned       IQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               icache_req_valid,
  output logic [ADDR_W-1:0]  icache_req_addr,
  input  logic               icache_resp_valid,
  input  logic [INSTR_W-1:0] icache_resp_instr,
  output logic [ADDR_W-1:0]  bp_pc,
  output logic [INSTR_W-1:0] bp_instr,
  input  logic               bp_taken,
  input  logic [ADDR_W-1:0]  bp_target,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic               dec_pred_taken,
  input  logic               dec_ready
);

  localparam int unsigned ENT_W = INSTR_W + ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(IQ_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;

  logic              w_issue;
  logic              w_accept;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_slot_free;
  logic [ENT_W-1:0]  w_resp_ent;
  logic [ENT_W-1:0]  w_head_ent;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  // --------------------------------------------------------------------------
  // Request / response qualification
  // --------------------------------------------------------------------------
  // A slot is reserved at issue time; the single outstanding response is
  // therefore always guaranteed room when it returns.
  assign w_slot_free = !w_full && (w_count < CNT_W'(IQ_DEPTH));

  // rst_n term keeps the strobe low while reset is held.
  assign w_issue = rst_n && rdy && (state_q == FETCH_IDLE) && w_slot_free
                   && !redirect_valid;

  assign w_accept = rdy && (state_q == FETCH_WAIT) && icache_resp_valid
                    && !drop_q && !redirect_valid;

`ifdef IFETCH_BYPASS_EN
  assign w_bypass = w_accept && w_empty && dec_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_resp_ent = {icache_resp_instr, pc_q, bp_taken};
  assign w_push     = w_accept && !w_bypass;
  assign w_flush    = rdy && redirect_valid;
  assign w_pop      = rdy && !redirect_valid && !w_empty && dec_ready;

  assign icache_req_valid = w_issue;
  assign icache_req_addr  = pc_q;
  assign bp_pc            = pc_q;
  assign bp_instr         = icache_resp_instr;

  // --------------------------------------------------------------------------
  // Fetch FSM and PC
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (rdy) begin
      if (redirect_valid) begin
        pc_d = redirect_pc;
        if (state_q == FETCH_WAIT) begin
          if (icache_resp_valid) begin
            // Response consumed (and discarded) in the redirect cycle.
            state_d = FETCH_IDLE;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
      end else begin
        case (state_q)
          FETCH_IDLE: begin
            if (w_issue) state_d = FETCH_WAIT;
          end
          FETCH_WAIT: begin
            if (icache_resp_valid) begin
              state_d = FETCH_IDLE;
              drop_d  = 1'b0;
              if (!drop_q) begin
                pc_d = bp_taken ? bp_target : (pc_q + ADDR_W'(INSTR_STEP));
              end
            end
          end
          default: state_d = FETCH_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction queue
  // --------------------------------------------------------------------------
  iq_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (IQ_DEPTH)
  ) u_iq_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (w_flush),
    .push_i      (w_push),
    .push_data_i (w_resp_ent),
    .pop_i       (w_pop),
    .head_data_o (w_head_ent),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  // Decode outputs are zero whenever nothing is presented, so stale storage
  // never leaks onto the bus.
  always_comb begin
    dec_valid      = 1'b0;
    dec_instr      = '0;
    dec_pc         = '0;
    dec_pred_taken = 1'b0;
    if (w_bypass) begin
      dec_valid                            = 1'b1;
      {dec_instr, dec_pc, dec_pred_taken}  = w_resp_ent;
    end else if (!w_empty) begin
      dec_valid                            = 1'b1;
      {dec_instr, dec_pc, dec_pred_taken}  = w_head_ent;
    end
  end

endmodule : ifetch_queue

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
// ============================================================================
// Module : tb_ifetch_queue
// Purpose: Self-checking bench for ifetch_queue: directed scenarios followed
//          by a randomized run against a transaction-level queue model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_queue;

  localparam int ADDR_W   = 32;
  localparam int INSTR_W  = 32;
  localparam int IQ_DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        taken;
  } ent_t;

  logic               clk;
  logic               rst_n;
  logic               rdy;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               icache_req_valid;
  logic [ADDR_W-1:0]  icache_req_addr;
  logic               icache_resp_valid;
  logic [INSTR_W-1:0] icache_resp_instr;
  logic [ADDR_W-1:0]  bp_pc;
  logic [INSTR_W-1:0] bp_instr;
  logic               bp_taken;
  logic [ADDR_W-1:0]  bp_target;
  logic               dec_valid;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;
  logic               dec_pred_taken;
  logic               dec_ready;

  int checks = 0;
  int errors = 0;

  // Bench predictor: low bits 2'b11 mean "taken", target from bits [11:2].
  assign bp_taken  = (bp_instr[1:0] == 2'b11);
  assign bp_target = {20'h0, bp_instr[11:2], 2'b00};

  ifetch_queue #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .IQ_DEPTH (IQ_DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdy               (rdy),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .icache_req_valid  (icache_req_valid),
    .icache_req_addr   (icache_req_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_instr (icache_resp_instr),
    .bp_pc             (bp_pc),
    .bp_instr          (bp_instr),
    .bp_taken          (bp_taken),
    .bp_target         (bp_target),
    .dec_valid         (dec_valid),
    .dec_instr         (dec_instr),
    .dec_pc            (dec_pc),
    .dec_pred_taken    (dec_pred_taken),
    .dec_ready         (dec_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs just after a falling edge, then settle.
  task automatic set_in(input logic rv, input logic [31:0] rpc, input logic rsp,
                        input logic [31:0] ins, input logic dr);
    redirect_valid    = rv;
    redirect_pc       = rpc;
    icache_resp_valid = rsp;
    icache_resp_instr = ins;
    dec_ready         = dr;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy   = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    icache_resp_valid = 1'b0; icache_resp_instr = '0;
    dec_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset values, then an asynchronous reset applied between clock edges.
  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    icache_resp_valid = 1'b0; icache_resp_instr = '0; dec_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %0b want 0", icache_req_valid); end
    checks++; if (icache_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got %h want 0", icache_req_addr); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rst_dec_valid got %0b want 0", dec_valid); end
    checks++; if (dec_pc !== 32'h0 || dec_instr !== 32'h0 || dec_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_dec_fields got %h/%h/%0b want 0", dec_pc, dec_instr, dec_pred_taken); end
    @(negedge clk);
    rst_n = 1'b1;
    // Two fetches held in the queue (dec_ready=0), pc advances to 0x8.
    for (int c = 0; c < 4; c++) begin
      set_in(1'b0, 32'h0, (c % 2) == 1, 32'h0000_0010, 1'b0);
      @(negedge clk);
    end
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++; if (icache_req_addr !== 32'h8 || dec_valid !== 1'b1) begin errors++; $display("FAIL pre_async_rst got addr %h dv %0b want 8 1", icache_req_addr, dec_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (dec_valid !== 1'b0 || icache_req_addr !== 32'h0 || icache_req_valid !== 1'b0) begin errors++; $display("FAIL async_rst got dv %0b addr %h rv %0b want 0 0 0", dec_valid, icache_req_addr, icache_req_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cache latency 2, no branches: requests every 3 cycles, dec_pc 0,4,8.
  task automatic test_sequential();
    logic        exp_req, exp_dv;
    logic [31:0] exp_addr, exp_pc;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      set_in(1'b0, 32'h0, (n % 3) == 2, 32'h0000_1000 + 32'(n << 4), 1'b1);
      exp_req  = (n % 3) == 0;
      exp_addr = 32'(4 * (n / 3));
`ifdef IFETCH_BYPASS_EN
      exp_dv = (n % 3) == 2;
      exp_pc = 32'(4 * (n / 3));
`else
      exp_dv = ((n % 3) == 0) && (n >= 3);
      exp_pc = 32'(4 * (n / 3) - 4);
`endif
      checks++; if (icache_req_valid !== exp_req) begin errors++; $display("FAIL seq_req_valid c%0d got %0b want %0b", n, icache_req_valid, exp_req); end
      if (exp_req) begin
        checks++; if (icache_req_addr !== exp_addr) begin errors++; $display("FAIL seq_req_addr c%0d got %h want %h", n, icache_req_addr, exp_addr); end
      end
      checks++; if (dec_valid !== exp_dv) begin errors++; $display("FAIL seq_dec_valid c%0d got %0b want %0b", n, dec_valid, exp_dv); end
      if (exp_dv) begin
        checks++; if (dec_pc !== exp_pc) begin errors++; $display("FAIL seq_dec_pc c%0d got %h want %h", n, dec_pc, exp_pc); end
      end
      @(negedge clk);
    end
  endtask

  // dec_ready=0: exactly IQ_DEPTH requests, then one pop frees one request.
  task automatic test_full();
    logic pend;
    int   nreq;
    do_reset();
    pend = 1'b0; nreq = 0;
    for (int n = 0; n < 16; n++) begin
      set_in(1'b0, 32'h0, pend, 32'h0000_2000, 1'b0);
      pend = icache_req_valid;
      if (icache_req_valid) nreq++;
      @(negedge clk);
    end
    checks++; if (nreq != IQ_DEPTH) begin errors++; $display("FAIL full_req_count got %0d want %0d", nreq, IQ_DEPTH); end
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++; if (icache_req_valid !== 1'b0 || dec_pc !== 32'h0) begin errors++; $display("FAIL full_pop_cycle got rv %0b pc %h want 0 0", icache_req_valid, dec_pc); end
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h10) begin errors++; $display("FAIL full_refill_req got rv %0b addr %h want 1 10", icache_req_valid, icache_req_addr); end
    checks++; if (dec_pc !== 32'h4) begin errors++; $display("FAIL full_new_head got %h want 4", dec_pc); end
    @(negedge clk);
  endtask

  // Predicted-taken branch at 0x10 retargets fetch to 0x100.
  task automatic test_branch();
    logic        pend, seen;
    logic [31:0] pend_addr, ins, log_a [8];
    int          nreq;
    do_reset();
    pend = 1'b0; seen = 1'b0; nreq = 0; pend_addr = '0;
    for (int i = 0; i < 8; i++) log_a[i] = 32'hDEAD_BEEF;
    for (int n = 0; n < 14; n++) begin
      ins = (pend_addr == 32'h10) ? 32'h0000_0103 : 32'h0000_2000;
      set_in(1'b0, 32'h0, pend, ins, 1'b1);
      if (dec_valid && dec_pc == 32'h10) begin
        seen = 1'b1;
        checks++; if (dec_pred_taken !== 1'b1 || dec_instr !== 32'h0000_0103) begin errors++; $display("FAIL br_dec_taken got %0b %h want 1 00000103", dec_pred_taken, dec_instr); end
      end
      pend = icache_req_valid;
      if (icache_req_valid) begin
        pend_addr = icache_req_addr;
        if (nreq < 8) log_a[nreq] = icache_req_addr;
        nreq++;
      end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL br_head_seen got 0 want 1"); end
    checks++; if (log_a[4] !== 32'h10) begin errors++; $display("FAIL br_req4 got %h want 10", log_a[4]); end
    checks++; if (log_a[5] !== 32'h100) begin errors++; $display("FAIL br_target_req got %h want 100", log_a[5]); end
    checks++; if (log_a[6] !== 32'h104) begin errors++; $display("FAIL br_after_target got %h want 104", log_a[6]); end
  endtask

  // Redirect while WAIT with two queued entries; late response discarded.
  task automatic test_redirect_wait();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(1'b0, 32'h0, (c % 2) == 1, 32'h0000_2000, 1'b0);
      @(negedge clk);
    end
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h8 || dec_pc !== 32'h0) begin errors++; $display("FAIL rdw_setup got rv %0b addr %h pc %h want 1 8 0", icache_req_valid, icache_req_addr, dec_pc); end
    @(negedge clk);
    set_in(1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    checks++; if (dec_valid !== 1'b1 || icache_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_redirect_cycle got dv %0b rv %0b want 1 0", dec_valid, icache_req_valid); end
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++; if (dec_valid !== 1'b0 || icache_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_flushed got dv %0b rv %0b want 0 0", dec_valid, icache_req_valid); end
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b1, 32'h0000_3000, 1'b1);
    checks++; if (dec_valid !== 1'b0 || icache_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_late_resp got dv %0b rv %0b want 0 0", dec_valid, icache_req_valid); end
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h200 || dec_valid !== 1'b0) begin errors++; $display("FAIL rdw_new_req got rv %0b addr %h dv %0b want 1 200 0", icache_req_valid, icache_req_addr, dec_valid); end
    @(negedge clk);
  endtask

  // Redirect in the same cycle as the response: nothing pushed.
  task automatic test_redirect_resp();
    do_reset();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    set_in(1'b1, 32'h300, 1'b1, 32'h0000_4000, 1'b1);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rdr_same_cycle got dv %0b want 0", dec_valid); end
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++; if (dec_valid !== 1'b0 || icache_req_valid !== 1'b1 || icache_req_addr !== 32'h300) begin errors++; $display("FAIL rdr_next got dv %0b rv %0b addr %h want 0 1 300", dec_valid, icache_req_valid, icache_req_addr); end
    @(negedge clk);
  endtask

  // rdy=0 for 5 cycles mid-WAIT: pulse lost, queue and FSM frozen.
  task automatic test_rdy_hold();
    do_reset();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); @(negedge clk);
    set_in(1'b0, 32'h0, 1'b1, 32'h0000_5000, 1'b0); @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); @(negedge clk);
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_in(1'b0, 32'h0, c == 2, 32'h0000_5100, 1'b1);
      checks++; if (icache_req_valid !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'h0) begin errors++; $display("FAIL hold_c%0d got rv %0b dv %0b pc %h want 0 1 0", c, icache_req_valid, dec_valid, dec_pc); end
      @(negedge clk);
    end
    rdy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checks++; if (icache_req_valid !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h0000_5000) begin errors++; $display("FAIL hold_after_c%0d got rv %0b dv %0b pc %h ins %h want 0 1 0 00005000", c, icache_req_valid, dec_valid, dec_pc, dec_instr); end
      @(negedge clk);
    end
  endtask

  // Fetch-to-decode latency for an empty queue.
  task automatic test_bypass();
    do_reset();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); @(negedge clk);
    set_in(1'b0, 32'h0, 1'b1, 32'h0000_6000, 1'b1);
`ifdef IFETCH_BYPASS_EN
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h0000_6000) begin errors++; $display("FAIL byp_same_cycle got dv %0b pc %h ins %h want 1 0 00006000", dec_valid, dec_pc, dec_instr); end
`else
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL byp_same_cycle got dv %0b want 0", dec_valid); end
`endif
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
`ifdef IFETCH_BYPASS_EN
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL byp_next_cycle got dv %0b want 0", dec_valid); end
`else
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h0000_6000) begin errors++; $display("FAIL byp_next_cycle got dv %0b pc %h ins %h want 1 0 00006000", dec_valid, dec_pc, dec_instr); end
`endif
    @(negedge clk);
  endtask

  // Random redirects, decode back-pressure and cache latency against a
  // queue-of-fetched-instructions model.
  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic        m_out, m_drop, resp_now, acc, byp, exp_req, exp_dv, tk;
    logic [31:0] m_pc, tgt;
    int          cd;
    do_reset();
    m_out = 1'b0; m_drop = 1'b0; m_pc = 32'h0; cd = 0;
    for (int c = 0; c < 3000; c++) begin
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFFC;
      dec_ready      = ($urandom_range(0, 3) != 0);
      resp_now       = 1'b0;
      if (cd > 0) begin
        cd--;
        resp_now = (cd == 0);
      end
      icache_resp_valid = resp_now;
      icache_resp_instr = $urandom;
      #1;
      tk  = (icache_resp_instr[1:0] == 2'b11);
      tgt = {20'h0, icache_resp_instr[11:2], 2'b00};
      e   = '{instr: icache_resp_instr, pc: m_pc, taken: tk};
      exp_req = !m_out && (q.size() < IQ_DEPTH) && !redirect_valid;
      acc     = resp_now && m_out && !m_drop && !redirect_valid;
      byp     = 1'b0;
`ifdef IFETCH_BYPASS_EN
      byp     = acc && (q.size() == 0) && dec_ready;
`endif
      exp_dv  = (q.size() > 0) || byp;
      checks++; if (icache_req_valid !== exp_req) begin errors++; $display("FAIL rnd_req_valid c%0d got %0b want %0b", c, icache_req_valid, exp_req); end
      if (exp_req) begin
        checks++; if (icache_req_addr !== m_pc) begin errors++; $display("FAIL rnd_req_addr c%0d got %h want %h", c, icache_req_addr, m_pc); end
      end
      checks++; if (dec_valid !== exp_dv) begin errors++; $display("FAIL rnd_dec_valid c%0d got %0b want %0b", c, dec_valid, exp_dv); end
      if (exp_dv) begin
        ent_t h;
        h = byp ? e : q[0];
        checks++;
        if (dec_instr !== h.instr || dec_pc !== h.pc || dec_pred_taken !== h.taken) begin
          errors++;
          $display("FAIL rnd_dec_head c%0d got %h/%h/%0b want %h/%h/%0b", c, dec_instr, dec_pc, dec_pred_taken, h.instr, h.pc, h.taken);
        end
      end
      // Model update for the coming clock edge.
      if (redirect_valid) begin
        q.delete();
        m_pc = redirect_pc;
        if (m_out) begin
          if (resp_now) begin m_out = 1'b0; m_drop = 1'b0; end
          else m_drop = 1'b1;
        end
      end else begin
        if (dec_ready && q.size() > 0) void'(q.pop_front());
        if (resp_now && m_out) begin
          if (m_drop) m_drop = 1'b0;
          else begin
            if (!byp) q.push_back(e);
            m_pc = tk ? tgt : m_pc + 32'd4;
          end
          m_out = 1'b0;
        end
        if (exp_req) m_out = 1'b1;
      end
      if (icache_req_valid) cd = $urandom_range(1, 3);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    icache_resp_valid = 1'b0; icache_resp_instr = '0; dec_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_full();
    test_branch();
    test_redirect_wait();
    test_redirect_resp();
    test_rdy_hold();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ifetch_queue

`default_nettype wire
